// File: rtl/echo_drain_pkg.sv
// rtl/echo_drain_pkg.sv - shared types and constants for the echo drain
package echo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int ECHO_WIDTH_DEFAULT = 32;
    localparam int STATS_W            = 16;

endpackage

// File: rtl/echo_drain_timer.sv
// rtl/echo_drain_timer.sv - loadable down-counter that flags done at zero
module echo_drain_timer #(
    parameter int DELAY_W = 8
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_val,
    output logic               done
);

    logic [DELAY_W-1:0] cnt_r;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - 1'b1;
        end
    end

    assign done = (cnt_r == '0);

endmodule

// File: rtl/echo_drain.sv
// rtl/echo_drain.sv - pops FIFO words, delays them, offers them as heard indications (optional ECHO_DRAIN_STATS_EN)
module echo_drain
    import echo_drain_pkg::*;
#(
    parameter int WIDTH   = ECHO_WIDTH_DEFAULT,
    parameter int DELAY   = 0,
    parameter int DELAY_W = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] fifo_first,
    input  logic             fifo_first__RDY,
    input  logic             fifo_deq__RDY,
    output logic             fifo_deq__ENA,
    output logic             ind_heard__ENA,
    output logic [WIDTH-1:0] ind_heard_v,
    input  logic             ind_heard__RDY,
    output logic             busy
`ifdef ECHO_DRAIN_STATS_EN
    ,
    output logic [STATS_W-1:0] msg_count,
    output logic [STATS_W-1:0] stall_count
`endif
);

    // A delay that does not fit the counter would silently truncate.
    if (DELAY < 0 || 64'(DELAY) >= (64'd1 << DELAY_W)) begin : g_delay_range
        $error("echo_drain: DELAY does not fit in DELAY_W bits");
    end

    localparam bit NO_DELAY = (DELAY == 0);

    state_t           state_r;
    state_t           state_nx;
    logic [WIDTH-1:0] hold_r;
    logic             avail;
    logic             hold_load;
    logic             timer_load;
    logic             timer_done;

    assign avail = fifo_first__RDY & fifo_deq__RDY;

    if (DELAY > 0) begin : g_timer
        echo_drain_timer #(
            .DELAY_W (DELAY_W)
        ) u_timer (
            .CLK      (CLK),
            .nRST     (nRST),
            .load     (timer_load),
            .load_val (DELAY_W'(DELAY - 1)),
            .done     (timer_done)
        );
    end else begin : g_no_timer
        logic unused_timer_load;
        assign unused_timer_load = timer_load;
        assign timer_done        = 1'b1;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Captures the head word only on the cycle it is popped.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hold_r <= '0;
        end else if (hold_load) begin
            hold_r <= fifo_first;
        end
    end

    // Next state and handshakes; a pop in SEND rides on the indication fire for back-to-back flow.
    always_comb begin
        state_nx       = state_r;
        fifo_deq__ENA  = 1'b0;
        ind_heard__ENA = 1'b0;
        hold_load      = 1'b0;
        timer_load     = 1'b0;
        case (state_r)
            IDLE: begin
                if (avail) begin
                    fifo_deq__ENA = 1'b1;
                    hold_load     = 1'b1;
                    timer_load    = 1'b1;
                    state_nx      = NO_DELAY ? SEND : WAIT;
                end
            end
            WAIT: begin
                if (timer_done) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                ind_heard__ENA = ind_heard__RDY;
                if (ind_heard__RDY) begin
                    if (avail) begin
                        fifo_deq__ENA = 1'b1;
                        hold_load     = 1'b1;
                        timer_load    = 1'b1;
                        state_nx      = NO_DELAY ? SEND : WAIT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (!nRST) begin
            fifo_deq__ENA  = 1'b0;
            ind_heard__ENA = 1'b0;
            hold_load      = 1'b0;
            timer_load     = 1'b0;
        end
    end

    assign ind_heard_v = (nRST && state_r == SEND) ? hold_r : '0;
    assign busy        = nRST && (state_r != IDLE);

`ifdef ECHO_DRAIN_STATS_EN
    // Message count wraps; stall count saturates.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            msg_count   <= '0;
            stall_count <= '0;
        end else begin
            if (ind_heard__ENA) begin
                msg_count <= msg_count + 1'b1;
            end
            if (state_r == SEND && !ind_heard__RDY && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_echo_drain.sv
// tb/tb_echo_drain.sv - scoreboard bench for echo_drain at DELAY 0, 3 and 5 (optional ECHO_DRAIN_STATS_EN)
module tb_echo_drain;

    logic        CLK = 1'b0;
    logic        nRST;

    logic [31:0] ff0, ff3, ff5;
    logic        ffr0, ffr3, ffr5;
    logic        dqr0, dqr3, dqr5;
    logic        ir0, ir3, ir5;
    logic        deq0, deq3, deq5;
    logic        ie0, ie3, ie5;
    logic [31:0] iv0, iv3, iv5;
    logic        busy0, busy3, busy5;
`ifdef ECHO_DRAIN_STATS_EN
    logic [15:0] mc0, mc3, mc5, sc0, sc3, sc5;
`endif

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    echo_drain #(.WIDTH(32), .DELAY(0), .DELAY_W(8)) dut0 (
        .CLK(CLK), .nRST(nRST), .fifo_first(ff0), .fifo_first__RDY(ffr0),
        .fifo_deq__RDY(dqr0), .fifo_deq__ENA(deq0), .ind_heard__ENA(ie0),
        .ind_heard_v(iv0), .ind_heard__RDY(ir0), .busy(busy0)
`ifdef ECHO_DRAIN_STATS_EN
        , .msg_count(mc0), .stall_count(sc0)
`endif
    );

    echo_drain #(.WIDTH(32), .DELAY(3), .DELAY_W(8)) dut3 (
        .CLK(CLK), .nRST(nRST), .fifo_first(ff3), .fifo_first__RDY(ffr3),
        .fifo_deq__RDY(dqr3), .fifo_deq__ENA(deq3), .ind_heard__ENA(ie3),
        .ind_heard_v(iv3), .ind_heard__RDY(ir3), .busy(busy3)
`ifdef ECHO_DRAIN_STATS_EN
        , .msg_count(mc3), .stall_count(sc3)
`endif
    );

    echo_drain #(.WIDTH(32), .DELAY(5), .DELAY_W(8)) dut5 (
        .CLK(CLK), .nRST(nRST), .fifo_first(ff5), .fifo_first__RDY(ffr5),
        .fifo_deq__RDY(dqr5), .fifo_deq__ENA(deq5), .ind_heard__ENA(ie5),
        .ind_heard_v(iv5), .ind_heard__RDY(ir5), .busy(busy5)
`ifdef ECHO_DRAIN_STATS_EN
        , .msg_count(mc5), .stall_count(sc5)
`endif
    );

    task automatic idle_inputs();
        ff0 = '0; ff3 = '0; ff5 = '0;
        ffr0 = 0; ffr3 = 0; ffr5 = 0;
        dqr0 = 0; dqr3 = 0; dqr5 = 0;
        ir0 = 0; ir3 = 0; ir5 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        ffr0 = 1; dqr0 = 1; ir0 = 1; ff0 = 32'h0000_00AB;
        ffr3 = 1; dqr3 = 1; ir3 = 1; ff3 = 32'h0000_00CD;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            total++; if (deq0 !== 1'b0 || ie0 !== 1'b0) $display("FAIL reset_ena0 c=%0d deq=%b ind=%b expected 0 0", c, deq0, ie0); else passed++;
            total++; if (busy0 !== 1'b0 || busy3 !== 1'b0) $display("FAIL reset_busy c=%0d busy0=%b busy3=%b expected 0 0", c, busy0, busy3); else passed++;
            total++; if (deq3 !== 1'b0 || iv0 !== 32'h0) $display("FAIL reset_deq3_v c=%0d deq3=%b v=%h expected 0 0", c, deq3, iv0); else passed++;
            @(posedge CLK); #1;
        end
        nRST = 1'b1;
        @(negedge CLK);
        total++; if (deq0 !== 1'b1) $display("FAIL reset_first_pop got %b expected 1", deq0); else passed++;
        @(posedge CLK); #1;
        ffr0 = 0; ffr3 = 0;
        @(negedge CLK);
        total++; if (ie0 !== 1'b1 || iv0 !== 32'h0000_00AB) $display("FAIL reset_first_ind ena=%b v=%h expected 1 000000ab", ie0, iv0); else passed++;
        @(posedge CLK); #1;
    endtask

    task automatic test_stream();
        logic [31:0] words [4];
        logic [31:0] want;
        int idx;
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_reset();
        idx = 0;
        ir0 = 1; dqr0 = 1;
        for (int c = 0; c < 8; c++) begin
            ffr0 = (idx < 4);
            ff0  = (idx < 4) ? words[idx] : 32'h0;
            @(negedge CLK);
            total++; if (deq0 !== (c < 4)) $display("FAIL stream_deq c=%0d got %b expected %b", c, deq0, (c < 4)); else passed++;
            total++; if (ie0 !== (c >= 1 && c <= 4)) $display("FAIL stream_ind c=%0d got %b expected %b", c, ie0, (c >= 1 && c <= 4)); else passed++;
            if (ie0) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL stream_extra c=%0d got %h expected none", c, iv0);
                else begin
                    want = exp_q.pop_front();
                    if (iv0 !== want) $display("FAIL stream_data c=%0d got %h expected %h", c, iv0, want); else passed++;
                end
            end
            if (deq0) begin
                exp_q.push_back(ff0);
                idx++;
            end
            @(posedge CLK); #1;
        end
        total++; if (exp_q.size() != 0) $display("FAIL stream_left got %0d expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_delay();
        logic [31:0] want;
        do_reset();
        ir3 = 1; dqr3 = 1;
        for (int c = 0; c < 11; c++) begin
            ffr3 = (c <= 4);
            ff3  = (c == 0) ? 32'hDEAD_BEEF : (32'hCAFE_F000 + 32'(c));
            @(negedge CLK);
            total++; if (deq3 !== (c == 0 || c == 4)) $display("FAIL delay_deq c=%0d got %b expected %b", c, deq3, (c == 0 || c == 4)); else passed++;
            total++; if (ie3 !== (c == 4 || c == 8)) $display("FAIL delay_ind c=%0d got %b expected %b", c, ie3, (c == 4 || c == 8)); else passed++;
            if (ie3) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL delay_extra c=%0d got %h expected none", c, iv3);
                else begin
                    want = exp_q.pop_front();
                    if (iv3 !== want) $display("FAIL delay_data c=%0d got %h expected %h", c, iv3, want); else passed++;
                end
            end
            if (deq3) exp_q.push_back(ff3);
            @(posedge CLK); #1;
        end
        total++; if (busy3 !== 1'b0 || exp_q.size() != 0) $display("FAIL delay_end busy=%b left=%0d expected 0 0", busy3, exp_q.size()); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] want;
        do_reset();
        dqr0 = 1;
        for (int c = 0; c < 9; c++) begin
            ir0  = !(c >= 1 && c <= 5);
            ffr0 = (c <= 6);
            ff0  = (c == 0) ? 32'h0000_00A5 : 32'h0000_005A;
            @(negedge CLK);
            total++; if (deq0 !== (c == 0 || c == 6)) $display("FAIL bp_deq c=%0d got %b expected %b", c, deq0, (c == 0 || c == 6)); else passed++;
            total++; if (ie0 !== (c == 6 || c == 7)) $display("FAIL bp_ind c=%0d got %b expected %b", c, ie0, (c == 6 || c == 7)); else passed++;
            if (c >= 1 && c <= 5) begin
                total++; if (iv0 !== 32'h0000_00A5 || busy0 !== 1'b1) $display("FAIL bp_hold c=%0d v=%h busy=%b expected 000000a5 1", c, iv0, busy0); else passed++;
            end
`ifdef ECHO_DRAIN_STATS_EN
            if (c == 7) begin
                total++; if (mc0 !== 16'd1 || sc0 !== 16'd5) $display("FAIL bp_stats msg=%0d stall=%0d expected 1 5", mc0, sc0); else passed++;
            end
`endif
            if (ie0) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL bp_extra c=%0d got %h expected none", c, iv0);
                else begin
                    want = exp_q.pop_front();
                    if (iv0 !== want) $display("FAIL bp_data c=%0d got %h expected %h", c, iv0, want); else passed++;
                end
            end
            if (deq0) exp_q.push_back(ff0);
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_empty_after_fire();
        do_reset();
        dqr0 = 1; ir0 = 1;
        ffr0 = 1; ff0 = 32'h0000_0077;
        @(negedge CLK);
        @(posedge CLK); #1;
        ffr0 = 0;
        @(negedge CLK);
        total++; if (ie0 !== 1'b1 || deq0 !== 1'b0) $display("FAIL empty_fire ind=%b deq=%b expected 1 0", ie0, deq0); else passed++;
        @(posedge CLK); #1;
        @(negedge CLK);
        total++; if (busy0 !== 1'b0 || deq0 !== 1'b0 || ie0 !== 1'b0 || iv0 !== 32'h0) $display("FAIL empty_idle busy=%b deq=%b ind=%b v=%h expected 0 0 0 0", busy0, deq0, ie0, iv0); else passed++;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        dqr5 = 1; ir5 = 1;
        ffr5 = 1; ff5 = 32'h1234_5678;
        @(negedge CLK);
        total++; if (deq5 !== 1'b1) $display("FAIL midwait_pop got %b expected 1", deq5); else passed++;
        @(posedge CLK); #1;
        ffr5 = 0;
        @(posedge CLK); #1;
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            total++; if (ie5 !== 1'b0 || busy5 !== 1'b0) $display("FAIL midwait_quiet c=%0d ind=%b busy=%b expected 0 0", c, ie5, busy5); else passed++;
            @(posedge CLK); #1;
        end
`ifdef ECHO_DRAIN_STATS_EN
        total++; if (mc5 !== 16'd0 || sc5 !== 16'd0) $display("FAIL midwait_stats msg=%0d stall=%0d expected 0 0", mc5, sc5); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_delay();
        test_backpressure();
        test_empty_after_fire();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
